// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// Register file with two combinational read ports, one write port with
// write-through bypass, and a per-register pending (scoreboard) bit.
// After reset the array is zeroed one entry per cycle; ready rises when done.
//
// Ports:
//   clk        in   clock, all state updates on posedge
//   reset      in   synchronous active-high reset
//   rs1, rs2   in   read addresses
//   rd         in   write address
//   WriteData  in   write data
//   RegWrite   in   write enable (also clears pending[rd])
//   IssueValid in   mark IssueRd as pending
//   IssueRd    in   destination of the issued producer
//   readData1/2 out read data (bypassed from same-cycle write)
//   busy1/2    out  read register has a pending producer
//   ready      out  clear sequence complete
//
// NREG must be a power of two and at least 4.
module regfile_scoreboard #(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned NREG     = 32,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned AW      = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] WriteData,
    input  logic            RegWrite,
    input  logic            IssueValid,
    input  logic [AW-1:0]   IssueRd,
    output logic [XLEN-1:0] readData1,
    output logic [XLEN-1:0] readData2,
    output logic            busy1,
    output logic            busy2,
    output logic            ready
);

    typedef enum logic {StClear, StReady} state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [NREG-1:0]   pending_q, pending_d;
    logic [XLEN-1:0]   regs_q [NREG];

    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [XLEN-1:0]   wr_data;
    logic              active;
    logic              wr_ok;
    logic              issue_ok;

    // Outputs are gated by reset directly so they read as idle while reset
    // is held, even before the first reset edge has been seen.
    assign active   = (state_q == StReady) && !reset;
    assign ready    = active;
    assign wr_ok    = RegWrite && !(ZERO_REG && (rd == '0));
    assign issue_ok = IssueValid && !(ZERO_REG && (IssueRd == '0));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        wr_en     = 1'b0;
        wr_addr   = rd;
        wr_data   = WriteData;
        if (reset) begin
            state_d   = StClear;
            cnt_d     = '0;
            pending_d = '0;
        end else if (state_q == StClear) begin
            wr_en   = 1'b1;
            wr_addr = cnt_q;
            wr_data = '0;
            cnt_d   = cnt_q + AW'(1);
            if (cnt_q == AW'(NREG - 1)) begin
                state_d = StReady;
            end
        end else begin
            if (wr_ok) begin
                wr_en         = 1'b1;
                pending_d[rd] = 1'b0;
            end
            // Applied after the clear so a same-cycle issue keeps the bit set.
            if (issue_ok) begin
                pending_d[IssueRd] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        pending_q <= pending_d;
    end

    // Array has no reset; its contents come only from the clear walk and writes.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    logic [AW-1:0]   rs_addr [2];
    logic [XLEN-1:0] rdata   [2];
    logic            rbusy   [2];

    assign rs_addr[0] = rs1;
    assign rs_addr[1] = rs2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata[p] = '0;
            rbusy[p] = 1'b0;
            if (active && !(ZERO_REG && (rs_addr[p] == '0))) begin
                if (RegWrite && (rd == rs_addr[p])) begin
                    rdata[p] = WriteData;
                end else begin
                    rdata[p] = regs_q[rs_addr[p]];
                end
                // A same-cycle write satisfies the reader, matching the bypass.
                rbusy[p] = pending_q[rs_addr[p]] && !(RegWrite && (rd == rs_addr[p]));
            end
        end
    end

    assign readData1 = rdata[0];
    assign readData2 = rdata[1];
    assign busy1     = rbusy[0];
    assign busy2     = rbusy[1];

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter XLEN, default 64, data width in bits of each register.
REQ-002 Parameter NREG, default 32, number of registers, power of two, minimum 4; AW = log2(NREG) is the address width.
REQ-003 Parameter ZERO_REG, default 1; when 1, register 0 is hardwired to zero.
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 rs1  in  AW  read port 1 address.
REQ-007 rs2  in  AW  read port 2 address.
REQ-008 rd  in  AW  write address.
REQ-009 WriteData  in  XLEN  write data.
REQ-010 RegWrite  in  1  write enable.
REQ-011 IssueValid  in  1  marks register IssueRd as pending (producer in flight).
REQ-012 IssueRd  in  AW  destination register of the issued producer.
REQ-013 readData1  out  XLEN  read port 1 data.
REQ-014 readData2  out  XLEN  read port 2 data.
REQ-015 busy1  out  1  rs1 has a pending write.
REQ-016 busy2  out  1  rs2 has a pending write.
REQ-017 ready  out  1  high once the clear sequence has completed; low while clearing.

Function
REQ-018 Two states: CLEAR and READY; AW-bit clear counter cnt.
REQ-019 CLEAR, reset low: write 0 to register[cnt], increment cnt; if cnt == NREG-1, go to READY.
REQ-020 READY persists until reset; ready = (state == READY).
REQ-021 In CLEAR, RegWrite and IssueValid are ignored; readData1/2 = 0; busy1/2 = 0.
REQ-022 In READY, RegWrite=1 writes WriteData to register[rd] at posedge; write latency 1 cycle.
REQ-023 With ZERO_REG=1, writes and issues to address 0 are ignored, and reads of address 0 return 0.
REQ-024 Reads are combinational. In READY, if RegWrite=1 and rd == rsN (and rsN is not a hardwired zero), readDataN = WriteData (write-through bypass); otherwise readDataN = register[rsN].
REQ-025 NREG-bit pending vector: IssueValid sets pending[IssueRd]; RegWrite clears pending[rd]; both take effect at posedge.
REQ-026 If issue and write target the same register in the same cycle, set wins, so pending stays 1.
REQ-027 busyN = pending[rsN] AND NOT (RegWrite AND rd == rsN); a same-cycle write releases busy combinationally, consistent with the bypass.
REQ-028 Read ports are independent; rs1 == rs2 returns identical data and busy on both ports.

Reset
REQ-029 Any posedge with reset=1: state <= CLEAR, cnt <= 0, pending <= 0; the register array is not written on that edge.
REQ-030 While reset is held: ready=0, readData1/2=0, busy1/2=0; cnt stays 0.
REQ-031 After reset deasserts, ready rises exactly NREG posedges later, and all registers read 0.
REQ-032 Reset asserted mid-clear or in READY restarts the full clear sequence from cnt=0.
REQ-033 No initial blocks are used for functional state; contents are defined only by the clear sequence and writes.

Verification
REQ-034 Default parameters; reset 2 cycles, then release -> ready=0 for 32 cycles, ready=1 on the 32nd posedge; then read every address -> 0.
REQ-035 Write rd=8, WriteData=0x1234 with rs1=8 in the same cycle -> readData1=0x1234 before the edge (bypass); next cycle with RegWrite=0 -> readData1=0x1234.
REQ-036 Write rd=0, data=0xFFFF; read rs2=0 -> readData2=0 both cycles; repeat with ZERO_REG=0 -> readData2=0xFFFF after the edge.
REQ-037 Issue rd=5, then rs1=5 -> busy1=1; RegWrite rd=5 with data 7 -> busy1=0 that cycle, readData1=7; simultaneous issue and write to 5 -> busy1=1 next cycle.
REQ-038 Assert reset at cnt=10 of the clear sequence, and also during READY with pending[5]=1 -> both cases: clear restarts, ready low for NREG cycles, busy1=0, register 5 reads 0.
REQ-039 XLEN=32, NREG=8: full clear in 8 cycles; write/read all 8 addresses with pattern 0xA5A5_0000+i -> read data matches.
